sp_mul_arbiter: RTL and testbench

//   Shares one sp_mul_plat multiplier between PORTS requesters with round-robin arbitration.

---
 rtl/sp_mul_arbiter_if.sv | 39 +++
 rtl/sp_mul_arbiter.sv | 113 +++++++++++
 tb/tb_sp_mul_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sp_mul_arbiter_if.sv
// sp_mul_arbiter_if
//   Bundles the requester-side bus and the multiplier-side handshake of
//   sp_mul_arbiter.
//   Requester side : req_in, a_in, b_in -> done_out, c_out, grant_out, busy_out
//   Multiplier side: mul_start_out, mul_a_out, mul_b_out -> mul_c_in, mul_ready_in
//   Port i operands are packed at [i*WIDTH +: WIDTH].
//   slave  : the arbiter's view.
//   master : the view of the environment (requesters plus multiplier).
interface sp_mul_arbiter_if #(
    parameter int WIDTH        = 24,
    parameter int OUTPUT_WIDTH = WIDTH*2,
    parameter int PORTS        = 4,
    parameter int IDXW         = 4
);
    logic [PORTS-1:0]        req_in;
    logic [PORTS*WIDTH-1:0]  a_in;
    logic [PORTS*WIDTH-1:0]  b_in;
    logic [PORTS-1:0]        done_out;
    logic [OUTPUT_WIDTH-1:0] c_out;
    logic [IDXW-1:0]         grant_out;
    logic                    busy_out;
    logic                    mul_start_out;
    logic [WIDTH-1:0]        mul_a_out;
    logic [WIDTH-1:0]        mul_b_out;
    logic [OUTPUT_WIDTH-1:0] mul_c_in;
    logic                    mul_ready_in;

    modport slave (
        input  req_in, a_in, b_in, mul_c_in, mul_ready_in,
        output done_out, c_out, grant_out, busy_out,
               mul_start_out, mul_a_out, mul_b_out
    );

    modport master (
        output req_in, a_in, b_in, mul_c_in, mul_ready_in,
        input  done_out, c_out, grant_out, busy_out,
               mul_start_out, mul_a_out, mul_b_out
    );
endinterface

// File: rtl/sp_mul_arbiter.sv
// sp_mul_arbiter
//   Shares one multiplier among PORTS requesters using round-robin arbitration.
//   It grants one requester and registers that requester's operands. It pulses
//   mul_start_out for one cycle, then waits for mul_ready_in. It then latches the
//   product into c_out and pulses done_out[grant] for one cycle.
//   Ports:
//     clk  - clock; all logic runs on the rising edge
//     rst  - synchronous active-high reset
//     bus  - sp_mul_arbiter_if.slave (requester bus plus multiplier handshake)
module sp_mul_arbiter #(
    parameter int WIDTH        = 24,
    parameter int OUTPUT_WIDTH = WIDTH*2,
    parameter int PORTS        = 4,
    parameter int IDXW         = 4
) (
    input  logic             clk,
    input  logic             rst,
    sp_mul_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                  r_state;
    logic [IDXW-1:0]         r_rr;
    logic [IDXW-1:0]         r_grant;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_b;
    logic                    r_start;
    logic                    r_busy;
    logic [PORTS-1:0]        r_done;
    logic [OUTPUT_WIDTH-1:0] r_c;

    logic                    w_found;
    logic [IDXW-1:0]         w_pick;
    int                      w_idx;
    logic [PORTS-1:0]        w_onehot;

    // Round-robin pick. The scan starts at rr+1 and wraps modulo PORTS.
    // The loop runs from the farthest offset down to the nearest one, so the
    // last match written is the closest requester after rr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = PORTS; k >= 1; k--) begin
            w_idx = (int'(r_rr) + k) % PORTS;
            if (bus.req_in[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IDXW'(w_idx);
            end
        end
    end

    assign w_onehot = PORTS'(1) << r_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rr    <= IDXW'(PORTS-1);
            r_grant <= IDXW'(PORTS-1);
            r_a     <= '0;
            r_b     <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= '0;
            r_c     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        // Operands are captured here. Later changes by the
                        // requester cannot affect this operation.
                        r_grant <= w_pick;
                        r_rr    <= w_pick;
                        r_a     <= bus.a_in[w_pick*WIDTH +: WIDTH];
                        r_b     <= bus.b_in[w_pick*WIDTH +: WIDTH];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Ready is only sampled here. A stale ready that arrives
                    // after a reset is therefore ignored.
                    if (bus.mul_ready_in) begin
                        r_c     <= bus.mul_c_in;
                        r_done  <= w_onehot;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.done_out      = r_done;
    assign bus.c_out         = r_c;
    assign bus.grant_out     = r_grant;
    assign bus.busy_out      = r_busy;
    assign bus.mul_start_out = r_start;
    assign bus.mul_a_out     = r_a;
    assign bus.mul_b_out     = r_b;

endmodule

// File: tb/tb_sp_mul_arbiter.sv
module tb_sp_mul_arbiter;

    localparam int W  = 24;
    localparam int OW = 48;
    localparam int P  = 4;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sp_mul_arbiter_if #(.WIDTH(W), .OUTPUT_WIDTH(OW), .PORTS(P), .IDXW(IW)) bus();

    sp_mul_arbiter #(.WIDTH(W), .OUTPUT_WIDTH(OW), .PORTS(P), .IDXW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Multiplier model. ready is high while idle and drops the cycle after
    // start. It rises again lat_cfg cycles after the start cycle (lat_cfg >= 2)
    // and presents the product of the operands seen at start.
    int            lat_cfg = 4;
    int            m_cnt   = 0;
    logic          m_ready = 1'b1;
    logic [OW-1:0] m_prod  = '0;
    logic [OW-1:0] m_c     = '0;
    always @(posedge clk) begin
        if (bus.mul_start_out) begin
            m_ready <= 1'b0;
            m_cnt   <= lat_cfg - 2;
            m_prod  <= {24'b0, bus.mul_a_out} * {24'b0, bus.mul_b_out};
            m_c     <= 48'h0BAD0BAD0BAD;
        end else if (!m_ready) begin
            if (m_cnt == 0) begin
                m_ready <= 1'b1;
                m_c     <= m_prod;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end
    assign bus.mul_ready_in = m_ready;
    assign bus.mul_c_in     = m_c;

    typedef struct {
        logic [3:0]        req;
        logic [3:0][W-1:0] a;
        logic [3:0][W-1:0] b;
        int                lat;
        logic [IW-1:0]     g;
        logic [OW-1:0]     c;
    } vec_t;

    vec_t tv [7];

    int checks = 0, failures = 0;
    int cyc = 0, n_start = 0, n_done = 0, start_cyc = 0, done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and record start and done events there.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.mul_start_out) begin n_start++; start_cyc = cyc; end
        if (|bus.done_out)     begin n_done++;  done_cyc  = cyc; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_done();
        int base = n_done;
        int n = 0;
        while (n_done == base && n < 200) begin step(); n++; end
        chk("done_timeout", 64'(n_done != base), 64'd1);
    endtask

    task automatic wait_start();
        int base = n_start;
        int n = 0;
        while (n_start == base && n < 200) begin step(); n++; end
        chk("start_timeout", 64'(n_start != base), 64'd1);
    endtask

    task automatic apply(input logic [3:0] req, input logic [3:0][W-1:0] a,
                         input logic [3:0][W-1:0] b, input int lat);
        bus.req_in = req;
        bus.a_in   = a;
        bus.b_in   = b;
        lat_cfg    = lat;
    endtask

    initial begin
        int s0;
        int d1;
        int nd;
        int ns;
        logic [3:0][W-1:0] a2, b2;

        // After reset rr=3. Expected grants follow rotation from there.
        tv[0] = '{req:4'b0100, a:{24'd0, 24'd3, 24'd0, 24'd0},
                  b:{24'd0, 24'd5, 24'd0, 24'd0}, lat:4, g:4'd2, c:48'd15};
        tv[1] = '{req:4'b0100, a:{24'd0, 24'hFFFFFF, 24'd0, 24'd0},
                  b:{24'd0, 24'hFFFFFF, 24'd0, 24'd0}, lat:2, g:4'd2, c:48'hFFFFFE000001};
        tv[2] = '{req:4'b0011, a:{24'd0, 24'd0, 24'd100, 24'd7},
                  b:{24'd0, 24'd0, 24'd200, 24'd9}, lat:2, g:4'd0, c:48'd63};
        tv[3] = '{req:4'b0011, a:{24'd0, 24'd0, 24'd100, 24'd7},
                  b:{24'd0, 24'd0, 24'd200, 24'd9}, lat:3, g:4'd1, c:48'd20000};
        tv[4] = '{req:4'b1001, a:{24'd12345, 24'd0, 24'd0, 24'd7},
                  b:{24'd2, 24'd0, 24'd0, 24'd9}, lat:2, g:4'd3, c:48'd24690};
        tv[5] = '{req:4'b1001, a:{24'd12345, 24'd0, 24'd0, 24'd7},
                  b:{24'd2, 24'd0, 24'd0, 24'd9}, lat:5, g:4'd0, c:48'd63};
        tv[6] = '{req:4'b1000, a:{24'd0, 24'd0, 24'd0, 24'd0},
                  b:{24'hFFFFFF, 24'd0, 24'd0, 24'd0}, lat:3, g:4'd3, c:48'd0};

        apply(4'b0000, '0, '0, 4);
        do_reset();

        // Reset values
        chk("rst_done",  64'(bus.done_out),      64'd0);
        chk("rst_c",     64'(bus.c_out),         64'd0);
        chk("rst_grant", 64'(bus.grant_out),     64'd3);
        chk("rst_busy",  64'(bus.busy_out),      64'd0);
        chk("rst_start", 64'(bus.mul_start_out), 64'd0);
        chk("rst_a",     64'(bus.mul_a_out),     64'd0);
        chk("rst_b",     64'(bus.mul_b_out),     64'd0);

        // Table vectors: one transaction each, with req held until done.
        for (int i = 0; i < 7; i++) begin
            s0 = n_start;
            apply(tv[i].req, tv[i].a, tv[i].b, tv[i].lat);
            wait_done();
            chk($sformatf("v%0d_grant", i),   64'(bus.grant_out), 64'(tv[i].g));
            chk($sformatf("v%0d_c", i),       64'(bus.c_out),     64'(tv[i].c));
            chk($sformatf("v%0d_done", i),    64'(bus.done_out),  64'(4'b0001 << tv[i].g));
            chk($sformatf("v%0d_nstart", i),  64'(n_start - s0),  64'd1);
            chk($sformatf("v%0d_latency", i), 64'(done_cyc - start_cyc), 64'(tv[i].lat + 1));
            chk($sformatf("v%0d_busy", i),    64'(bus.busy_out),  64'd1);
            bus.req_in = 4'b0000;
            step();
            chk($sformatf("v%0d_done_pulse", i), 64'(bus.done_out), 64'd0);
        end

        // All four ports requesting and held: strict rotation 0,1,2,3,0.
        do_reset();
        s0 = n_start;
        nd = n_done;
        apply(4'b1111, {24'd5, 24'd4, 24'd3, 24'd2}, {24'd40, 24'd30, 24'd20, 24'd10}, 2);
        for (int k = 0; k < 5; k++) begin
            wait_done();
            chk($sformatf("rr%0d_grant", k), 64'(bus.grant_out), 64'(k % 4));
            chk($sformatf("rr%0d_done", k),  64'(bus.done_out),  64'(4'b0001 << (k % 4)));
            chk($sformatf("rr%0d_c", k),     64'(bus.c_out),
                64'((k % 4 + 2) * (k % 4 + 1) * 10));
        end
        bus.req_in = 4'b0000;
        step(); step();
        chk("rr_nstart", 64'(n_start - s0), 64'd5);
        chk("rr_ndone",  64'(n_done - nd),  64'd5);

        // Back-to-back requests on port 1: rr wraps from 3 to port 1, and the
        // next start comes two cycles after done.
        do_reset();
        apply(4'b0010, {24'd0, 24'd0, 24'd6, 24'd0}, {24'd0, 24'd0, 24'd7, 24'd0}, 3);
        wait_done();
        chk("b2b_grant1", 64'(bus.grant_out), 64'd1);
        chk("b2b_c1",     64'(bus.c_out),     64'd42);
        d1 = done_cyc;
        wait_start();
        chk("b2b_restart", 64'(start_cyc - d1), 64'd2);
        wait_done();
        chk("b2b_grant2", 64'(bus.grant_out), 64'd1);
        chk("b2b_done2",  64'(bus.done_out),  64'b0010);
        bus.req_in = 4'b0000;
        step(); step();

        // Reset during WAIT: the late ready must be ignored.
        do_reset();
        apply(4'b0100, {24'd0, 24'd9, 24'd0, 24'd0}, {24'd0, 24'd9, 24'd0, 24'd0}, 5);
        wait_start();
        step(); step();
        rst = 1'b1;
        bus.req_in = 4'b0000;
        nd = n_done;
        ns = n_start;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("rstw_no_done",  64'(n_done - nd),   64'd0);
        chk("rstw_no_start", 64'(n_start - ns),  64'd0);
        chk("rstw_c",        64'(bus.c_out),     64'd0);
        chk("rstw_busy",     64'(bus.busy_out),  64'd0);
        chk("rstw_grant",    64'(bus.grant_out), 64'd3);
        apply(4'b0011, {24'd0, 24'd0, 24'd8, 24'd6}, {24'd0, 24'd0, 24'd8, 24'd7}, 2);
        wait_done();
        chk("rstw_regrant", 64'(bus.grant_out), 64'd0);
        chk("rstw_c2",      64'(bus.c_out),     64'd42);
        bus.req_in = 4'b0000;
        step(); step();

        // req dropped and operands changed after grant: done still pulses,
        // and the product uses the operands captured at grant.
        apply(4'b0100, {24'd0, 24'd11, 24'd0, 24'd0}, {24'd0, 24'd13, 24'd0, 24'd0}, 5);
        wait_start();
        step();
        a2 = {24'd99, 24'd99, 24'd99, 24'd99};
        b2 = {24'd77, 24'd77, 24'd77, 24'd77};
        bus.req_in = 4'b0000;
        bus.a_in   = a2;
        bus.b_in   = b2;
        wait_done();
        chk("drop_grant", 64'(bus.grant_out), 64'd2);
        chk("drop_done",  64'(bus.done_out),  64'b0100);
        chk("drop_c",     64'(bus.c_out),     64'd143);
        step(); step();
        chk("drop_idle_busy", 64'(bus.busy_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
